// File: rtl/alib_bitstream_fifo_if.sv
// Handshake bundle for alib_bitstream_fifo.
// master drives requests, slave is the FIFO.
interface alib_bitstream_fifo_if #(
    parameter int BUF_BITS     = 256,
    parameter int WIDTH_INPUT  = 16,
    parameter int WIDTH_OUTPUT = 8
);
    localparam int LW  = $clog2(BUF_BITS) + 1;
    localparam int WLW = $clog2(WIDTH_INPUT) + 1;
    localparam int RLW = $clog2(WIDTH_OUTPUT) + 1;

    logic                    i_flush;
    logic                    i_wr_valid;
    logic                    o_wr_ready;
    logic [WIDTH_INPUT-1:0]  i_wr_data;
    logic [WLW-1:0]          i_wr_len;
    logic                    i_rd_valid;
    logic                    o_rd_ready;
    logic [RLW-1:0]          i_rd_len;
    logic [WIDTH_OUTPUT-1:0] o_rd_data;
    logic                    o_rd_dvalid;
    logic [LW-1:0]           o_level;
    logic                    o_empty;
    logic                    o_full;

    modport master (
        output i_flush, i_wr_valid, i_wr_data, i_wr_len,
        output i_rd_valid, i_rd_len,
        input  o_wr_ready, o_rd_ready, o_rd_data, o_rd_dvalid,
        input  o_level, o_empty, o_full
    );

    modport slave (
        input  i_flush, i_wr_valid, i_wr_data, i_wr_len,
        input  i_rd_valid, i_rd_len,
        output o_wr_ready, o_rd_ready, o_rd_data, o_rd_dvalid,
        output o_level, o_empty, o_full
    );
endinterface

// File: rtl/alib_bitstream_fifo.sv
// Variable-length bit FIFO, MSB-first by default.
// Define ALIB_BITFIFO_LSB_FIRST_EN for LSB-first bit ordering.
module alib_bitstream_fifo #(
    parameter int BUF_BITS     = 256,
    parameter int WIDTH_INPUT  = 16,
    parameter int WIDTH_OUTPUT = 8
) (
    input logic             i_clk,
    input logic             i_rst,
    alib_bitstream_fifo_if.slave bus
);
    localparam int PW  = $clog2(BUF_BITS);
    localparam int LW  = PW + 1;
    localparam int WLW = $clog2(WIDTH_INPUT) + 1;
    localparam int RLW = $clog2(WIDTH_OUTPUT) + 1;

    logic [BUF_BITS-1:0]     buf_q, buf_d;
    logic [BUF_BITS-1:0]     wvec, wmask, wvec_rot, wmask_rot;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [LW-1:0]           level, level_d, wr_len_l, rd_len_l;
    logic [WLW-1:0]          wlen;
    logic [RLW-1:0]          rlen;
    logic [WIDTH_INPUT-1:0]  wbits;
    logic [WIDTH_OUTPUT-1:0] rbits, rdata, rd_data_q;
    logic                    wr_fire, rd_fire, dvalid_q;

    assign wlen = (bus.i_wr_len > WLW'(WIDTH_INPUT)) ?
                  WLW'(WIDTH_INPUT) : bus.i_wr_len;
    assign rlen = (bus.i_rd_len > RLW'(WIDTH_OUTPUT)) ?
                  RLW'(WIDTH_OUTPUT) : bus.i_rd_len;
    assign wr_len_l = LW'(wlen);
    assign rd_len_l = LW'(rlen);

    assign bus.o_wr_ready = !bus.i_flush &&
                            (level + wr_len_l <= LW'(BUF_BITS));
    assign bus.o_rd_ready = !bus.i_flush && (level >= rd_len_l);
    assign wr_fire = bus.i_wr_valid && bus.o_wr_ready;
    assign rd_fire = bus.i_rd_valid && bus.o_rd_ready;

    // wbits/rbits hold beats oldest-first at index 0
`ifdef ALIB_BITFIFO_LSB_FIRST_EN
    assign wbits = bus.i_wr_data;
    assign rdata = rbits;
`else
    logic [WIDTH_INPUT-1:0]  wshift;
    logic [WIDTH_OUTPUT-1:0] rrev;

    assign wshift = bus.i_wr_data << (WLW'(WIDTH_INPUT) - wlen);
    for (genvar k = 0; k < WIDTH_INPUT; k++) begin : g_wrev
        assign wbits[k] = wshift[WIDTH_INPUT-1-k];
    end
    for (genvar k = 0; k < WIDTH_OUTPUT; k++) begin : g_rrev
        assign rrev[k] = rbits[WIDTH_OUTPUT-1-k];
    end
    assign rdata = rrev >> (RLW'(WIDTH_OUTPUT) - rlen);
`endif

    // Rotations let a beat straddle the buffer end
    assign wvec  = BUF_BITS'(wbits);
    assign wmask = ~({BUF_BITS{1'b1}} << wlen);
    assign wvec_rot  = (wvec << wr_ptr) |
                       (wvec >> (LW'(BUF_BITS) - LW'(wr_ptr)));
    assign wmask_rot = (wmask << wr_ptr) |
                       (wmask >> (LW'(BUF_BITS) - LW'(wr_ptr)));
    assign buf_d = (buf_q & ~wmask_rot) | (wvec_rot & wmask_rot);

    assign rbits = WIDTH_OUTPUT'((buf_q >> rd_ptr) |
                   (buf_q << (LW'(BUF_BITS) - LW'(rd_ptr)))) &
                   ~({WIDTH_OUTPUT{1'b1}} << rlen);

    assign level_d = level + (wr_fire ? wr_len_l : '0)
                           - (rd_fire ? rd_len_l : '0);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            buf_q     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            rd_data_q <= '0;
            dvalid_q  <= 1'b0;
        end else if (bus.i_flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            dvalid_q <= 1'b0;
        end else begin
            if (wr_fire) begin
                buf_q  <= buf_d;
                wr_ptr <= PW'(LW'(wr_ptr) + wr_len_l);
            end
            if (rd_fire) begin
                rd_ptr    <= PW'(LW'(rd_ptr) + rd_len_l);
                rd_data_q <= rdata;
            end
            dvalid_q <= rd_fire;
            level    <= level_d;
        end
    end

    assign bus.o_rd_data   = rd_data_q;
    assign bus.o_rd_dvalid = dvalid_q;
    assign bus.o_level     = level;
    assign bus.o_empty     = (level == '0);
    assign bus.o_full      = (level > LW'(BUF_BITS - WIDTH_INPUT));
endmodule

// File: tb/tb_alib_bitstream_fifo.sv
// Scoreboard bench for alib_bitstream_fifo (BUF_BITS=32).
// A bit-queue model predicts readiness, level and read data.
module tb_alib_bitstream_fifo;
    localparam int BB = 32;
    localparam int WI = 16;
    localparam int WO = 8;
`ifdef ALIB_BITFIFO_LSB_FIRST_EN
    localparam logic [7:0] PACK_EXP = 8'h9D;
`else
    localparam logic [7:0] PACK_EXP = 8'hB3;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   fails;
    bit   model_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_exp;

    alib_bitstream_fifo_if #(
        .BUF_BITS(BB), .WIDTH_INPUT(WI), .WIDTH_OUTPUT(WO)
    ) bus ();

    alib_bitstream_fifo #(
        .BUF_BITS(BB), .WIDTH_INPUT(WI), .WIDTH_OUTPUT(WO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic beat(input bit wv, input logic [15:0] wd,
                        input logic [4:0] wl, input bit rv,
                        input logic [3:0] rl, input bit fl);
        int wn, rn;
        bit wok, rok, exp_wr, exp_rd, b;
        logic [7:0] d;
        wn = (wl > 5'(WI)) ? WI : int'(wl);
        rn = (rl > 4'(WO)) ? WO : int'(rl);
        bus.i_wr_valid = wv;
        bus.i_wr_data  = wd;
        bus.i_wr_len   = wl;
        bus.i_rd_valid = rv;
        bus.i_rd_len   = rl;
        bus.i_flush    = fl;
        #1;
        exp_wr = !fl && (model_q.size() + wn <= BB);
        exp_rd = !fl && (model_q.size() >= rn);
        check("wr_ready", 32'(bus.o_wr_ready), 32'(exp_wr));
        check("rd_ready", 32'(bus.o_rd_ready), 32'(exp_rd));
        wok = wv && exp_wr;
        rok = rv && exp_rd;
        if (fl) model_q.delete();
        if (rok) begin
            d = '0;
            for (int k = 0; k < rn; k++) begin
                b = model_q.pop_front();
`ifdef ALIB_BITFIFO_LSB_FIRST_EN
                d[k] = b;
`else
                d[rn-1-k] = b;
`endif
            end
            exp_q.push_back(d);
        end
        if (wok) begin
            for (int k = 0; k < wn; k++) begin
`ifdef ALIB_BITFIFO_LSB_FIRST_EN
                model_q.push_back(wd[k]);
`else
                model_q.push_back(wd[wn-1-k]);
`endif
            end
        end
        @(posedge clk);
        #1;
        bus.i_wr_valid = 1'b0;
        bus.i_rd_valid = 1'b0;
        bus.i_flush    = 1'b0;
        check("dvalid", 32'(bus.o_rd_dvalid), 32'(rok));
        if (bus.o_rd_dvalid) begin
            if (exp_q.size() == 0) begin
                check("dvalid_extra", 32'd1, 32'd0);
            end else begin
                last_exp = exp_q.pop_front();
                check("rd_data", 32'(bus.o_rd_data), 32'(last_exp));
            end
        end
        check("level", 32'(bus.o_level), 32'(model_q.size()));
        check("empty", 32'(bus.o_empty), 32'(model_q.size() == 0));
        check("full", 32'(bus.o_full), 32'(model_q.size() > BB - WI));
    endtask

    task automatic wr(input logic [15:0] wd, input logic [4:0] wl);
        beat(1'b1, wd, wl, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] rl);
        beat(1'b0, 16'h0, 5'd0, 1'b1, rl, 1'b0);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        last_exp = '0;
        rst = 1'b0;
        bus.i_flush    = 1'b0;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_data  = '0;
        bus.i_wr_len   = '0;
        bus.i_rd_valid = 1'b0;
        bus.i_rd_len   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", 32'(bus.o_level), 32'd0);
        check("rst_dvalid", 32'(bus.o_rd_dvalid), 32'd0);
        check("rst_data", 32'(bus.o_rd_data), 32'd0);
        check("rst_empty", 32'(bus.o_empty), 32'd1);
        rst = 1'b1;

        // Asynchronous reset mid-stream with a data pulse pending
        wr(16'hBEEF, 5'd16);
        beat(1'b1, 16'h0ABC, 5'd12, 1'b1, 4'd8, 1'b0);
        check("pre_rst_level", 32'(bus.o_level), 32'd20);
        bus.i_wr_len = 5'd16;
        bus.i_rd_len = 4'd8;
        #2 rst = 1'b0;
        #1;
        check("arst_level", 32'(bus.o_level), 32'd0);
        check("arst_dvalid", 32'(bus.o_rd_dvalid), 32'd0);
        check("arst_wr_ready", 32'(bus.o_wr_ready), 32'd1);
        check("arst_rd_ready", 32'(bus.o_rd_ready), 32'd0);
        model_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;

        // Bit packing
        wr(16'h0005, 5'd3);
        wr(16'h0013, 5'd5);
        rd(4'd8);
        check("pack", 32'(bus.o_rd_data), 32'(PACK_EXP));

        // Zero-length and over-length beats
        rd(4'd0);
        check("len0_data", 32'(bus.o_rd_data), 32'd0);
        wr(16'hC0DE, 5'd31);
        rd(4'd15);
        rd(4'd12);
        rd(4'd8);

        // Wrap-around across the buffer end
        wr(16'hA5C3, 5'd16);
        wr(16'hA5C3, 5'd16);
        repeat (3) rd(4'd8);
        wr(16'h1234, 5'd16);
        repeat (5) rd(4'd8);

        // Full and refusal
        beat(1'b0, 16'h0, 5'd0, 1'b0, 4'd0, 1'b1);
        wr(16'h5A5A, 5'd16);
        wr(16'h00E7, 5'd8);
        wr(16'hFFFF, 5'd16);
        check("refuse_level", 32'(bus.o_level), 32'd24);
        wr(16'h0081, 5'd8);
        check("full_flag", 32'(bus.o_full), 32'd1);

        // Simultaneous read and write
        beat(1'b0, 16'h0, 5'd0, 1'b0, 4'd0, 1'b1);
        wr(16'h006D, 5'd8);
        beat(1'b1, 16'h9F31, 5'd16, 1'b1, 4'd8, 1'b0);
        check("simul_level", 32'(bus.o_level), 32'd16);
        rd(4'd8);
        rd(4'd4);
        rd(4'd8);

        // Flush with traffic; earlier read data survives flush
        wr(16'h7E42, 5'd16);
        rd(4'd8);
        beat(1'b1, 16'hFFFF, 5'd4, 1'b1, 4'd4, 1'b1);
        check("flush_hold", 32'(bus.o_rd_data), 32'(last_exp));
        check("flush_level", 32'(bus.o_level), 32'd0);

        // Random traffic including straddling beats
        for (int n = 0; n < 400; n++) begin
            beat(1'($urandom), 16'($urandom),
                 5'($urandom_range(0, 20)), 1'($urandom),
                 4'($urandom_range(0, 10)),
                 ($urandom_range(0, 40) == 0));
        end

        check("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
